// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader_pkg
// Description : Shared debug-dump constants, state encodings and byte helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_reader_pkg;

    localparam int DBG_NUM_REGS   = 32;
    localparam int DBG_ADDR_WIDTH = 5;
    localparam int BYTE_CNT_W     = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_SEND = ST_SEND,
        S_NEXT = ST_NEXT,
        S_DONE = ST_DONE
    } dump_state_e;

    // Byte cnt of a word; cnt 0 is the most significant byte unless lsb_first.
    function automatic logic [7:0] word_byte(
        input logic [31:0]           word,
        input logic [BYTE_CNT_W-1:0] cnt,
        input logic                  lsb_first
    );
        logic [BYTE_CNT_W-1:0] sel;
        sel = lsb_first ? cnt : (BYTE_CNT_W'(BYTES_PER_WORD - 1) - cnt);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_serializer.sv
`default_nettype none
// ============================================================================
// Module      : word_byte_serializer
// Description : Snapshots one 32-bit word and emits it as 4 valid/ready bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module word_byte_serializer
    import regfile_dump_reader_pkg::*;
#(
    parameter int LSB_FIRST = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_load,
    input  logic        i_send,
    input  logic [31:0] i_word,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_word_done
);

    logic [31:0]           r_word_q;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic                  w_xfer;
    logic                  w_last;

    assign w_xfer = i_send & i_tx_ready;
    assign w_last = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // The word is captured only on load, so later register-file writes cannot leak in.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_word_q   <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_word_q   <= i_word;
            r_byte_cnt <= '0;
        end else if (w_xfer && !w_last) begin
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
        end
    end

    assign o_tx_valid  = i_send;
    assign o_tx_data   = i_send ? word_byte(r_word_q, r_byte_cnt, (LSB_FIRST != 0)) : 8'h00;
    assign o_word_done = w_xfer & w_last;

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks the register file read port and streams every word as bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NUM_REGS   = DBG_NUM_REGS,
    parameter int ADDR_WIDTH = DBG_ADDR_WIDTH,
    parameter int LSB_FIRST  = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_DUMP_START,
    output logic [ADDR_WIDTH-1:0] O_DUMP_REG_ADDR,
    input  logic [31:0]           I_DUMP_REG_DATA,
    output logic [7:0]            O_TX_DATA,
    output logic                  O_TX_VALID,
    input  logic                  I_TX_READY,
    output logic                  O_DUMP_BUSY,
    output logic                  O_DUMP_DONE
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_e           r_state;
    dump_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  w_load;
    logic                  w_send;
    logic                  w_word_done;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_send      = 1'b0;
        O_DUMP_BUSY = 1'b1;
        O_DUMP_DONE = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                O_DUMP_BUSY = 1'b0;
                if (I_DUMP_START) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                w_send = 1'b1;
                if (w_word_done) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt = (r_index == c_LAST_IDX) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                O_DUMP_DONE = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                O_DUMP_BUSY = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Index saturates at the last register; only a fresh start rewinds it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_index <= '0;
        end else if ((r_state == S_IDLE) && I_DUMP_START) begin
            r_index <= '0;
        end else if ((r_state == S_NEXT) && (r_index != c_LAST_IDX)) begin
            r_index <= r_index + ADDR_WIDTH'(1);
        end
    end

    assign O_DUMP_REG_ADDR = r_index;

    word_byte_serializer #(
        .LSB_FIRST (LSB_FIRST)
    ) u_serializer (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_load      (w_load),
        .i_send      (w_send),
        .i_word      (I_DUMP_REG_DATA),
        .i_tx_ready  (I_TX_READY),
        .o_tx_data   (O_TX_DATA),
        .o_tx_valid  (O_TX_VALID),
        .o_word_done (w_word_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Scoreboard bench for regfile_dump_reader (MSB-first and LSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        ready0 = 1'b1, ready1 = 1'b1;
    logic [4:0]  addr0, addr1;
    logic [31:0] rd0, rd1;
    logic [7:0]  data0, data1;
    logic        valid0, valid1, busy0, busy1, done0, done1;

    logic [31:0] regs [0:31];
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_bytes0 = 0, n_bytes1 = 0, n_extra0 = 0, n_extra1 = 0, n_done = 0;
    logic p_valid = 1'b0, p_ready = 1'b0, p_done = 1'b0;
    logic [7:0] p_data = 8'h00;
    bit seen3, changed, done_seen;

    always #5 CLK = ~CLK;

    assign rd0 = regs[addr0];
    assign rd1 = regs[addr1];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_WIDTH(5), .LSB_FIRST(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .I_DUMP_START(start0), .O_DUMP_REG_ADDR(addr0),
        .I_DUMP_REG_DATA(rd0), .O_TX_DATA(data0), .O_TX_VALID(valid0),
        .I_TX_READY(ready0), .O_DUMP_BUSY(busy0), .O_DUMP_DONE(done0)
    );

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_WIDTH(5), .LSB_FIRST(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .I_DUMP_START(start1), .O_DUMP_REG_ADDR(addr1),
        .I_DUMP_REG_DATA(rd1), .O_TX_DATA(data1), .O_TX_VALID(valid1),
        .I_TX_READY(ready1), .O_DUMP_BUSY(busy1), .O_DUMP_DONE(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected byte stream of the first nbytes of a dump, from the current register image.
    task automatic push_dump(input bit lsb, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            logic [31:0] w;
            int          k;
            w = regs[b / 4];
            k = lsb ? (b % 4) : (3 - (b % 4));
            if (lsb) q1.push_back(8'(w >> (8 * k)));
            else     q0.push_back(8'(w >> (8 * k)));
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
            p_done  = 1'b0;
        end else begin
            if (p_valid && !p_ready) begin
                check_eq("hold_valid", 32'(valid0), 1);
                check_eq("hold_data", 32'(data0), 32'(p_data));
            end
            if (done0) begin
                check_eq("done_single", 32'(p_done), 0);
                n_done++;
            end
            if (valid0 && ready0) begin
                n_bytes0++;
                if (q0.size() == 0) n_extra0++;
                else check_eq("byte_msb", 32'(data0), 32'(q0.pop_front()));
            end
            if (valid1 && ready1) begin
                n_bytes1++;
                if (q1.size() == 0) n_extra1++;
                else check_eq("byte_lsb", 32'(data1), 32'(q1.pop_front()));
            end
            p_valid = valid0;
            p_ready = ready0;
            p_data  = data0;
            p_done  = done0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
        regs[5] = 32'hDEADBEEF;
        regs[3] = 32'h11223344;

        cyc(); cyc();
        RESET = 1'b0;
        cyc();
        check_eq("rst_valid", 32'(valid0), 0);
        check_eq("rst_busy",  32'(busy0), 0);
        check_eq("rst_done",  32'(done0), 0);
        check_eq("rst_addr",  32'(addr0), 0);
        check_eq("rst_data",  32'(data0), 0);

        // Dump 1: full speed on both byte orders, with latency checks.
        push_dump(0, 128);
        push_dump(1, 128);
        start0 = 1'b1; start1 = 1'b1;
        cyc();
        start0 = 1'b0; start1 = 1'b0;
        for (int c = 1; c <= 194; c++) begin
            if (c == 1)   check_eq("d1_c1_valid", 32'(valid0), 0);
            if (c == 2)   check_eq("d1_c2_valid", 32'(valid0), 1);
            if (c == 192) check_eq("d1_c192_done", 32'(done0), 0);
            if (c == 193) begin
                check_eq("d1_c193_done", 32'(done0), 1);
                check_eq("d1_c193_busy", 32'(busy0), 1);
            end
            if (c == 194) begin
                check_eq("d1_c194_done", 32'(done0), 0);
                check_eq("d1_c194_busy", 32'(busy0), 0);
            end
            cyc();
        end
        check_eq("d1_bytes_msb", n_bytes0, 128);
        check_eq("d1_bytes_lsb", n_bytes1, 128);
        check_eq("d1_q0_left", q0.size(), 0);
        check_eq("d1_q1_left", q1.size(), 0);
        check_eq("d1_done_cnt", n_done, 1);
        check_eq("d1_busy_lsb", 32'(busy1), 0);

        // Dump 2: backpressure on reg 0 byte 2, snapshot of reg 3, ignored mid-dump start.
        n_bytes0 = 0; n_done = 0;
        push_dump(0, 128);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        seen3 = 0; changed = 0; done_seen = 0;
        for (int c = 1; c <= 400 && !done_seen; c++) begin
            ready0 = !(c >= 4 && c <= 6);
            start0 = (c == 50);
            if (c >= 4 && c <= 6) begin
                check_eq("bp_valid", 32'(valid0), 1);
                check_eq("bp_data", 32'(data0), 32'h02);
            end
            if (seen3 && !changed) begin
                regs[3] = 32'h55667788;
                changed = 1;
            end
            if (!seen3 && addr0 == 5'd3) seen3 = 1;
            if (done0) done_seen = 1;
            cyc();
        end
        ready0 = 1'b1;
        start0 = 1'b0;
        check_eq("d2_done_seen", 32'(done_seen), 1);
        check_eq("d2_bytes", n_bytes0, 128);
        check_eq("d2_q0_left", q0.size(), 0);
        check_eq("d2_done_cnt", n_done, 1);
        cyc();
        check_eq("d2_idle_busy", 32'(busy0), 0);

        // Dumps 3+4: start held through DONE restarts at register 0.
        n_bytes0 = 0; n_done = 0;
        push_dump(0, 128);
        push_dump(0, 128);
        start0 = 1'b1;
        cyc();
        for (int c = 1; c <= 390; c++) begin
            if (c == 194) check_eq("b2b_idle_busy", 32'(busy0), 0);
            if (c == 195) begin
                check_eq("b2b_load_busy", 32'(busy0), 1);
                check_eq("b2b_load_addr", 32'(addr0), 0);
            end
            if (c == 196) check_eq("b2b_first_valid", 32'(valid0), 1);
            if (c == 200) start0 = 1'b0;
            cyc();
        end
        check_eq("b2b_bytes", n_bytes0, 256);
        check_eq("b2b_q0_left", q0.size(), 0);
        check_eq("b2b_done_cnt", n_done, 2);

        // Dump 5: asynchronous reset at register 10, byte 1.
        n_bytes0 = 0; n_done = 0;
        push_dump(0, 41);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int c = 1; c < 63; c++) cyc();
        check_eq("mid_addr", 32'(addr0), 10);
        check_eq("mid_data", 32'(data0), 32'(regs[10][23:16]));
        RESET = 1'b1;
        #1;
        check_eq("arst_valid", 32'(valid0), 0);
        check_eq("arst_busy",  32'(busy0), 0);
        check_eq("arst_done",  32'(done0), 0);
        check_eq("arst_addr",  32'(addr0), 0);
        check_eq("arst_data",  32'(data0), 0);
        cyc();
        RESET = 1'b0;
        cyc(); cyc();
        check_eq("arst_bytes", n_bytes0, 41);
        check_eq("arst_q0_left", q0.size(), 0);
        check_eq("arst_no_done", n_done, 0);

        // Dump 6: restart after abort begins at register 0.
        n_bytes0 = 0; n_done = 0;
        push_dump(0, 128);
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 300 && !done_seen; c++) begin
            if (c == 2) check_eq("rs_first_byte", 32'(data0), 32'(regs[0][31:24]));
            if (done0) done_seen = 1;
            cyc();
        end
        cyc();
        check_eq("rs_done_seen", 32'(done_seen), 1);
        check_eq("rs_bytes", n_bytes0, 128);
        check_eq("rs_q0_left", q0.size(), 0);
        check_eq("extra_msb", n_extra0, 0);
        check_eq("extra_lsb", n_extra1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
